// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit shift register: hold, shift right/left, parallel load and preset,
// with a shift counter that strobes word_valid once per WIDTH accumulated shifts.
module shift_reg_universal #(
  parameter int unsigned           WIDTH      = 6,
  parameter logic [WIDTH-1:0]      PRESET_VAL = {WIDTH{1'b1}},
  localparam int unsigned          CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_valid
);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_d, q_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             word_valid_d, word_valid_q;
  logic             shift;

  always_comb begin
    q_d          = q_q;
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    shift        = 1'b0;
    if (preset) begin
      q_d   = PRESET_VAL;
      cnt_d = '0;
    end else if (en) begin
      unique case (mode)
        ModeHold: ;
        ModeRight: begin
          q_d   = {sin_r, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        ModeLeft: begin
          q_d   = {q_q[WIDTH-2:0], sin_l};
          shift = 1'b1;
        end
        ModeLoad: begin
          q_d   = pin;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Both directions share one counter; a word completes on the WIDTH-th shift.
    if (shift) begin
      if (cnt_q == CntLast) begin
        cnt_d        = '0;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q          <= '0;
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign q          = q_q;
  assign sout_r     = q_q[0];
  assign sout_l     = q_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench: vector table plus directed sequences on a WIDTH=6 instance, and
// randomized stimulus on WIDTH=6/2/32 instances against an arithmetic reference model.
module tb_shift_reg_universal;

  logic        clk = 1'b0;
  logic        reset;
  logic        preset, en, sin_r, sin_l;
  logic [1:0]  mode;
  logic [31:0] pin;

  logic [5:0]  q6;  logic [2:0] cnt6;  logic sr6, sl6, wv6;
  logic [1:0]  q2;  logic [1:0] cnt2;  logic sr2, sl2, wv2;
  logic [31:0] q32; logic [5:0] cnt32; logic sr32, sl32, wv32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_universal #(.WIDTH(6)) u_dut6 (
    .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .pin(pin[5:0]), .q(q6), .sout_r(sr6), .sout_l(sl6), .shift_cnt(cnt6),
    .word_valid(wv6)
  );
  shift_reg_universal #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .pin(pin[1:0]), .q(q2), .sout_r(sr2), .sout_l(sl2), .shift_cnt(cnt2),
    .word_valid(wv2)
  );
  shift_reg_universal #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .pin(pin), .q(q32), .sout_r(sr32), .sout_l(sl32), .shift_cnt(cnt32),
    .word_valid(wv32)
  );

  // Reference model: index 0 -> WIDTH 6, 1 -> WIDTH 2, 2 -> WIDTH 32.
  int          m_w[3] = '{6, 2, 32};
  logic [31:0] m_q[3];
  int          m_cnt[3];
  logic        m_wv[3];

  function automatic logic [31:0] mask_of(int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = '0; m_cnt[i] = 0; m_wv[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] mk;
      mk = mask_of(m_w[i]);
      m_wv[i] = 1'b0;
      if (!reset) begin
        m_q[i] = '0; m_cnt[i] = 0;
      end else if (preset) begin
        m_q[i] = mk; m_cnt[i] = 0;
      end else if (en && mode == 2'd3) begin
        m_q[i] = pin & mk; m_cnt[i] = 0;
      end else if (en && (mode == 2'd1 || mode == 2'd2)) begin
        if (mode == 2'd1) m_q[i] = (m_q[i] >> 1) | (32'(sin_r) << (m_w[i] - 1));
        else              m_q[i] = ((m_q[i] << 1) | 32'(sin_l)) & mk;
        m_wv[i]  = (m_cnt[i] + 1 == m_w[i]);
        m_cnt[i] = (m_cnt[i] + 1) % m_w[i];
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model follows the inputs present at the edge, sampling is #1 later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_models();
    chk("m6_q",    32'(q6),    m_q[0]);  chk("m6_cnt",  32'(cnt6),  32'(m_cnt[0]));
    chk("m6_wv",   32'(wv6),   32'(m_wv[0]));
    chk("m2_q",    32'(q2),    m_q[1]);  chk("m2_cnt",  32'(cnt2),  32'(m_cnt[1]));
    chk("m2_wv",   32'(wv2),   32'(m_wv[1]));
    chk("m32_q",   q32,        m_q[2]);  chk("m32_cnt", 32'(cnt32), 32'(m_cnt[2]));
    chk("m32_wv",  32'(wv32),  32'(m_wv[2]));
    chk("m32_sor", 32'(sr32),  32'(m_q[2][0]));
    chk("m32_sol", 32'(sl32),  32'(m_q[2][31]));
  endtask

  task automatic drive(logic p, logic e, logic [1:0] m, logic r, logic l, logic [31:0] d);
    preset = p; en = e; mode = m; sin_r = r; sin_l = l; pin = d;
  endtask

  typedef struct {
    logic       preset;
    logic       en;
    logic [1:0] mode;
    logic       sr;
    logic       sl;
    logic [5:0] pin;
    logic [5:0] eq;
    int         ecnt;
    logic       ewv;
  } vec_t;

  function automatic vec_t mkv(logic p, logic e, logic [1:0] m, logic r, logic l,
                               logic [5:0] d, logic [5:0] eq, int ec, logic ew);
    vec_t v;
    v.preset = p; v.en = e; v.mode = m; v.sr = r; v.sl = l; v.pin = d;
    v.eq = eq; v.ecnt = ec; v.ewv = ew;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   wv_seen;
    logic exp_sout[6];

    // ---------------- reset state
    drive(0, 0, 2'd0, 0, 0, '0);
    reset = 1'b0;
    model_clear();
    tick(); tick();
    chk("rst_q", 32'(q6), 0); chk("rst_cnt", 32'(cnt6), 0); chk("rst_wv", 32'(wv6), 0);
    reset = 1'b1;

    // ---------------- vector table (WIDTH=6)
    vecs.push_back(mkv(0, 1, 2'd3, 0, 0, 6'b111000, 6'b111000, 0, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 1, 0, 6'b0,      6'b111100, 1, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 0, 0, 6'b0,      6'b011110, 2, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 1, 0, 6'b0,      6'b101111, 3, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 1, 0, 6'b0,      6'b110111, 4, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 0, 0, 6'b0,      6'b011011, 5, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 0, 0, 6'b0,      6'b001101, 0, 1));
    vecs.push_back(mkv(0, 1, 2'd0, 1, 1, 6'b0,      6'b001101, 0, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 0, 1, 6'b0,      6'b011011, 1, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 1, 0, 6'b0,      6'b110110, 2, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 0, 1, 6'b0,      6'b101101, 3, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 0, 1, 6'b0,      6'b011011, 4, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 1, 0, 6'b0,      6'b110110, 5, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 1, 0, 6'b0,      6'b101100, 0, 1));
    vecs.push_back(mkv(0, 0, 2'd1, 1, 1, 6'b0,      6'b101100, 0, 0));
    vecs.push_back(mkv(1, 1, 2'd1, 0, 0, 6'b0,      6'b111111, 0, 0));
    vecs.push_back(mkv(0, 1, 2'd1, 0, 1, 6'b0,      6'b011111, 1, 0));
    vecs.push_back(mkv(0, 1, 2'd2, 1, 0, 6'b0,      6'b111110, 2, 0));
    vecs.push_back(mkv(0, 1, 2'd3, 1, 1, 6'b010101, 6'b010101, 0, 0));
    foreach (vecs[i]) begin
      drive(vecs[i].preset, vecs[i].en, vecs[i].mode, vecs[i].sr, vecs[i].sl,
            32'(vecs[i].pin));
      tick();
      chk($sformatf("vec%0d_q", i),   32'(q6),   32'(vecs[i].eq));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt6), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_wv", i),  32'(wv6),  32'(vecs[i].ewv));
      chk($sformatf("vec%0d_sor", i), 32'(sr6),  32'(vecs[i].eq[0]));
      chk($sformatf("vec%0d_sol", i), 32'(sl6),  32'(vecs[i].eq[5]));
    end

    // ---------------- async reset mid-cycle while a strobe is showing
    drive(0, 1, 2'd3, 0, 0, 32'h2A);
    tick();
    drive(0, 1, 2'd1, 1, 0, '0);
    repeat (6) tick();
    chk("pre_rst_wv", 32'(wv6), 1);
    #3 reset = 1'b0;
    #1;
    model_clear();
    chk("arst_q", 32'(q6), 0); chk("arst_cnt", 32'(cnt6), 0); chk("arst_wv", 32'(wv6), 0);
    tick();
    chk("arst_hold_q", 32'(q6), 0);
    reset = 1'b1;

    // ---------------- parallel load then serial out
    drive(0, 1, 2'd3, 0, 0, 32'h32);
    tick();
    exp_sout = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive(0, 1, 2'd1, 0, 0, '0);
    wv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("sout_r%0d", k), 32'(sr6), 32'(exp_sout[k]));
      tick();
      if (wv6) wv_seen++;
    end
    chk("serout_q", 32'(q6), 0);
    chk("serout_words", 32'(wv_seen), 1);

    // ---------------- preset mid-word overrides a shift
    drive(0, 1, 2'd1, 1, 0, '0);
    repeat (3) tick();
    chk("pre3_cnt", 32'(cnt6), 3);
    drive(1, 1, 2'd1, 0, 0, '0);
    tick();
    chk("preset_q", 32'(q6), 32'h3F); chk("preset_cnt", 32'(cnt6), 0);
    chk("preset_wv", 32'(wv6), 0);
    drive(0, 1, 2'd1, 0, 0, '0);
    wv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      sin_r = 1'($urandom);
      tick();
      if (wv6) wv_seen++;
    end
    chk("preset_words", 32'(wv_seen), 1);
    chk("preset_wv_last", 32'(wv6), 1);

    // ---------------- enable gating freezes the counter
    begin
      int exp_cnt[10] = '{1, 2, 3, 3, 3, 3, 3, 4, 5, 0};
      drive(0, 1, 2'd3, 0, 0, '0);
      tick();
      wv_seen = 0;
      for (int k = 0; k < 10; k++) begin
        drive(0, (k < 3 || k > 6), 2'd2, 0, 1'($urandom), '0);
        tick();
        if (wv6) wv_seen++;
        chk($sformatf("engate_cnt%0d", k), 32'(cnt6), 32'(exp_cnt[k]));
      end
      chk("engate_words", 32'(wv_seen), 1);
    end

    // ---------------- randomized, all widths against the model
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
            2'($urandom), 1'($urandom), 1'($urandom), $urandom);
      tick();
      check_models();
    end

    // ---------------- continuous shifting: strobe period equals WIDTH
    drive(0, 1, 2'd3, 0, 0, '0);
    tick();
    for (int k = 1; k <= 64; k++) begin
      drive(0, 1, (k > 32) ? 2'd2 : 2'd1, 1'($urandom), 1'($urandom), '0);
      tick();
      check_models();
      chk($sformatf("period2_%0d", k),  32'(wv2),  32'((k % 2) == 0));
      chk($sformatf("period32_%0d", k), 32'(wv32), 32'((k % 32) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register: WIDTH-bit register with hold, shift-right, shift-left and parallel-load modes, plus a synchronous preset. It also keeps a shift counter and emits a one-cycle `word_valid` strobe each time WIDTH shifts have accumulated a complete word. It replaces fixed-width serial-in/serial-out registers in serialiser/deserialiser paths, so the same block can frame serial data in either direction.

## Interface

Parameters:
- WIDTH, 6, register width in bits; legal range 2..32.
- PRESET_VAL, all ones (WIDTH bits), value loaded by `preset`.
- Derived localparam CNT_W = $clog2(WIDTH+1), width of the shift counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- preset  in  1  synchronous, active-high; loads PRESET_VAL.
- en  in  1  operation enable; when low, `q` and `shift_cnt` hold.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  in  1  serial input for shift right; enters at q[WIDTH-1].
- sin_l  in  1  serial input for shift left; enters at q[0].
- pin  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- sout_r  out  1  serial output of shift right, = q[0].
- sout_l  out  1  serial output of shift left, = q[WIDTH-1].
- shift_cnt  out  CNT_W  number of shifts since the last load, preset, reset or word boundary.
- word_valid  out  1  one-cycle strobe marking a completed word.

## Operation

- Priority order: reset (async) > preset > en/mode.
- reset low: q=0, shift_cnt=0, word_valid=0 immediately, independent of clk. These values hold while reset is low.
- preset high at an edge: q=PRESET_VAL, shift_cnt=0, word_valid=0. `en` and `mode` are ignored.
- en low at an edge (no preset): q and shift_cnt hold, word_valid=0.
- en high at an edge, by mode:
  - 00 (hold): q and shift_cnt hold; word_valid=0.
  - 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
  - 10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
  - 11 (parallel load): q <= pin, shift_cnt=0, word_valid=0.
- Shift counter, on each shift (mode 01 or 10 with en high):
  - If shift_cnt == WIDTH-1: shift_cnt wraps to 0 and word_valid=1 for exactly one cycle.
  - Otherwise: shift_cnt increments and word_valid=0.
- Mixed directions count together. Changing mode mid-word does not clear the counter.
- sout_r and sout_l are taken directly from q, so they are glitch-free registered values.
- A shift-right chain is formed by connecting sout_r to the next block's sin_r. A shift-left chain uses sout_l to sin_l.

## Timing

- Every change to q, shift_cnt and word_valid takes effect at a rising clk edge, with one exception: the reset assertion is asynchronous.
- Latency:
  - Parallel load: pin is visible on q one cycle after the load edge.
  - Serial: a bit reaches the far-end serial output WIDTH-1 edges after the edge that captured it.
- word_valid is asserted in the cycle that follows the WIDTH-th shift edge. During that cycle q holds the complete word.
- Continuous shifting produces word_valid once every WIDTH cycles.
- Reset release is synchronised externally. The first active edge after release acts normally.
- Reset asserted mid-word: the partial word and the count are discarded.
- preset and parallel load mid-word: the count restarts at 0 and no strobe is produced.
- en low mid-word: the count is frozen and resumes counting when en returns high.

## Test plan

- Reset: drive q=6'b101010 via load, pulse reset low between edges -> q=0, shift_cnt=0 and word_valid=0 before the next edge.
- Shift right (WIDTH=6): apply sin_r = 1,0,1,1,0,0 over 6 edges -> q=6'b001101, word_valid high only in the cycle after the 6th edge, shift_cnt=0. Applying the same bits as sin_l in shift-left mode -> q=6'b101100.
- Parallel load and serial out: load pin=6'b110010, then shift right 6 times with sin_r=0 -> sout_r sequence 0,1,0,0,1,1, final q=0, one word_valid.
- Preset and priority: after 3 shifts assert preset together with mode=01 -> q=6'b111111, shift_cnt=0, no strobe. 6 more shifts -> a single strobe.
- Enable gating: shift 3 times, hold en low for 4 edges, shift 3 more times -> shift_cnt sequence 1,2,3,3,3,3,3,4,5,0, word_valid asserted once.
- Parameter sweep: WIDTH=2 and WIDTH=32 with continuous shifting -> word_valid period 2 and 32 cycles respectively; q matches a reference shift model.
